// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_GNT;
  logic              IF_DONE;
  logic [DATA_W-1:0] IF_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WDATA;
  logic              D_GNT;
  logic              D_DONE;
  logic [DATA_W-1:0] D_RDATA;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              BUSY;

  modport slave (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_RDATA,
    output IF_GNT, IF_DONE, IF_RDATA, D_GNT, D_DONE, D_RDATA,
    output MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE, BUSY
  );

  modport master (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, MEM_RDATA,
    input  IF_GNT, IF_DONE, IF_RDATA, D_GNT, D_DONE, D_RDATA,
    input  MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE, BUSY
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction
// fetch and the data path; every output is registered.
module mem_port_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  CLK,
  input logic                  RST,
  mem_port_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [7:0] LP_CNT_LOAD = 8'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic              r_owner_d;
  logic              r_we;
  logic              r_last_d;
  logic              r_if_gnt;
  logic              r_d_gnt;
  logic              r_if_done;
  logic              r_d_done;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_any_req;
  logic              w_pick_d;
  logic              w_cnt_zero;

  // On a tie the side that was not served last wins.
  assign w_any_req  = bus.IF_REQ | bus.D_REQ;
  assign w_pick_d   = bus.D_REQ & (~bus.IF_REQ | ~r_last_d);
  assign w_cnt_zero = (r_cnt == 8'd0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (w_cnt_zero) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt       <= 8'd0;
      r_owner_d   <= 1'b0;
      r_we        <= 1'b0;
      r_last_d    <= 1'b1;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_gnt  <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_busy    <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d   <= w_pick_d;
            r_we        <= w_pick_d & bus.D_WE;
            r_mem_addr  <= w_pick_d ? bus.D_ADDR : bus.IF_ADDR;
            if (w_pick_d) r_mem_wdata <= bus.D_WDATA;
            r_cnt       <= LP_CNT_LOAD;
            r_if_gnt    <= ~w_pick_d;
            r_d_gnt     <= w_pick_d;
            r_mem_read  <= ~(w_pick_d & bus.D_WE);
            r_mem_write <= w_pick_d & bus.D_WE;
          end
        end
        S_ACCESS: begin
          // Read data is taken at the edge that closes the last strobe cycle.
          if (w_cnt_zero) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_if_done   <= ~r_owner_d;
            r_d_done    <= r_owner_d;
            r_last_d    <= r_owner_d;
            if (!r_we) begin
              if (r_owner_d) r_d_rdata  <= bus.MEM_RDATA;
              else           r_if_rdata <= bus.MEM_RDATA;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IF_GNT    = r_if_gnt;
  assign bus.IF_DONE   = r_if_done;
  assign bus.IF_RDATA  = r_if_rdata;
  assign bus.D_GNT     = r_d_gnt;
  assign bus.D_DONE    = r_d_done;
  assign bus.D_RDATA   = r_d_rdata;
  assign bus.MEM_ADDR  = r_mem_addr;
  assign bus.MEM_WDATA = r_mem_wdata;
  assign bus.MEM_READ  = r_mem_read;
  assign bus.MEM_WRITE = r_mem_write;
  assign bus.BUSY      = r_busy;
endmodule
